ddr_frame_wr_ctrl: RTL and testbench
====================================

# ddr_frame_wr_ctrl

Write-side frame address generator between the camera write FIFO and the DDR burst controller. On each `wr_load` pulse from the bank switcher it latches `wr_bank`, then issues burst write requests that walk that bank's frame buffer linearly. Each request is sized to the data available in the FIFO. When a full frame has been written it raises `frame_write_done`, which the bank switcher uses to decide when to flip banks.

## Interface
- `ADDR_W`, 24: DDR word-address width. Bank select is `burst_addr[ADDR_W-1:ADDR_W-2]`.
- `LEN_W`, 9: burst length field width.
- `BURST_LEN`, 256: maximum words per burst. Must be ≤ 2^LEN_W − 1.
- `FRAME_WORDS`, 307200: words per frame. Must be ≤ 2^(ADDR_W-2).
- `USEDW_W`, 10: FIFO fill-count width.

Ports:
- `clk`  in  1: system clock. All logic is on the rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `wr_bank`  in  2: target bank. Sampled only on `wr_load`.
- `wr_load`  in  1: one-cycle pulse that starts a new frame.
- `fifo_usedw`  in  USEDW_W: words currently in the write FIFO.
- `burst_req`  out  1: burst request. Held until acknowledged.
- `burst_addr`  out  ADDR_W: start word address of the burst.
- `burst_len`  out  LEN_W: words in the burst.
- `burst_ack`  in  1: controller accepted the request.
- `burst_done`  in  1: one-cycle pulse when the burst's last word has been written.
- `frame_write_done`  out  1: level signal. High from frame completion until the next `wr_load`.

## Operation
- States:
  - IDLE: post-reset. Waits for `wr_load`.
  - WAIT_DATA: waits for `fifo_usedw ≥ cur_len`.
  - REQ: `burst_req` high. Waits for `burst_ack`.
  - BURST: waits for `burst_done`.
  - DONE: frame complete.
- `cur_len = min(BURST_LEN, FRAME_WORDS − word_cnt)`. This is computed combinationally from the registered `word_cnt`.
- `wr_load` in IDLE, WAIT_DATA or DONE:
  - bank ← `wr_bank`, offset ← 0, `word_cnt` ← 0, `frame_write_done` ← 0.
  - Next state is WAIT_DATA.
- WAIT_DATA → REQ when the fill condition holds. On that edge `burst_addr` ← {bank, offset}, `burst_len` ← `cur_len`, `burst_req` ← 1.
- REQ → BURST on `burst_ack`. `burst_req` drops on the same edge. `burst_addr`/`burst_len` hold until the next REQ entry.
- BURST, on `burst_done`:
  - offset += `burst_len`; `word_cnt` += `burst_len`.
  - If the new `word_cnt` equals `FRAME_WORDS`: go to DONE and set `frame_write_done` ← 1.
  - Otherwise: go to WAIT_DATA.
- `wr_load` during REQ or BURST is never dropped and never aborts the burst.
  - It sets `load_pend` and captures `wr_bank` into `pend_bank`.
  - On the `burst_done` edge the pending load takes priority over the frame-complete check. The block re-initialises from `pend_bank` and goes to WAIT_DATA. `frame_write_done` stays 0.
  - A second `wr_load` while pending overwrites `pend_bank`.
- Arithmetic:
  - offset is ADDR_W−2 bits. Its sum never wraps given the `FRAME_WORDS` constraint.
  - `word_cnt` is $clog2(FRAME_WORDS+1) bits.
- `burst_ack` outside REQ and `burst_done` outside BURST are ignored.

## Timing
- Reset values: `burst_req`=0, `burst_addr`=0, `burst_len`=0, `frame_write_done`=0, state IDLE, `load_pend`=0.
- `wr_load` → `burst_req`: 2 cycles minimum (1 to WAIT_DATA, 1 to REQ), assuming the FIFO is already filled.
- `burst_done` → next `burst_req`: 2 cycles minimum.
- `burst_done` → `frame_write_done` high: 1 cycle.
- `wr_load` → `frame_write_done` low: 1 cycle.
- Reset asserted mid-burst returns to reset values immediately. The DDR controller is reset on the same `rst_n`.
- `wr_load` is produced on the opposite clock edge. It is a full-cycle pulse and is sampled directly, with no synchroniser.

## Structure
- Shared package `ddr_frame_pkg`:
  - state enum.
  - `BANK_W` = 2.
  - default `FRAME_WORDS` and `BURST_LEN`, shared with the read-side controller.
- No sub-modules. A single FSM plus address and count registers.
- The read-side counterpart, `ddr_frame_rd_ctrl`, will reuse the package and mirror this structure.

## Test plan
1. `FRAME_WORDS`=600, `BURST_LEN`=256, `wr_bank`=2'b01, `wr_load`, FIFO always full, ack after 1 cycle:
   - bursts at addr 0x400000/256, 0x400100/256, 0x400200/88.
   - `frame_write_done` rises 1 cycle after the third `burst_done`.
2. `fifo_usedw` held at 255 for 50 cycles, then 256 → no `burst_req` until the cycle after usedw reaches 256.
3. `burst_ack` delayed 10 cycles → `burst_req`, `burst_addr` and `burst_len` are stable for all 10 cycles.
4. `wr_load` with `wr_bank`=2'b10 issued mid-BURST of bank 01:
   - the current burst completes.
   - the next request is at 0x800000/256.
   - `frame_write_done` never rises for bank 01.
5. `frame_write_done` high, then `wr_load` (`wr_bank`=2'b00) → `frame_write_done` low next cycle, first burst at 0x000000.
6. `rst_n` pulsed low during REQ → all outputs 0 asynchronously. No `burst_req` afterwards until a new `wr_load`.

Source files
------------

// File: rtl/ddr_frame_pkg.sv
// Shared types and defaults for the DDR frame read/write address
// controllers.
package ddr_frame_pkg;

  localparam int BANK_W          = 2;
  localparam int DEF_FRAME_WORDS = 307200;
  localparam int DEF_BURST_LEN   = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_DATA,
    ST_REQ,
    ST_BURST,
    ST_DONE
  } frame_state_e;

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/ddr_frame_wr_ctrl.sv
// Write-side frame address generator: walks one bank's frame buffer
// in FIFO-sized bursts and flags frame completion.
module ddr_frame_wr_ctrl
  import ddr_frame_pkg::*;
#(
  parameter int ADDR_W      = 24,
  parameter int LEN_W       = 9,
  parameter int BURST_LEN   = DEF_BURST_LEN,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int USEDW_W     = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [BANK_W-1:0]  wr_bank,
  input  logic               wr_load,
  input  logic [USEDW_W-1:0] fifo_usedw,
  output logic               burst_req,
  output logic [ADDR_W-1:0]  burst_addr,
  output logic [LEN_W-1:0]   burst_len,
  input  logic               burst_ack,
  input  logic               burst_done,
  output logic               frame_write_done
);

  localparam int OFF_W = ADDR_W - BANK_W;
  localparam int CNT_W = $clog2(FRAME_WORDS + 1);

  frame_state_e state_q, state_d;

  logic [BANK_W-1:0] bank_q, bank_d;
  logic [BANK_W-1:0] pend_bank_q, pend_bank_d;
  logic              load_pend_q, load_pend_d;
  logic [OFF_W-1:0]  offset_q, offset_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              done_q, done_d;

  logic [LEN_W-1:0]  cur_len;
  logic              fill_ok;
  logic [CNT_W-1:0]  cnt_next;
  logic [OFF_W-1:0]  off_next;
  logic [BANK_W-1:0] load_bank;

  // Last burst of a frame shrinks to the words still outstanding.
  assign cur_len = LEN_W'(min_i(BURST_LEN,
                   FRAME_WORDS - int'(word_cnt_q)));
  assign fill_ok = int'(fifo_usedw) >= int'(cur_len);

  assign cnt_next  = word_cnt_q + CNT_W'(len_q);
  assign off_next  = offset_q + OFF_W'(len_q);
  assign load_bank = wr_load ? wr_bank : pend_bank_q;

  always_comb begin
    state_d     = state_q;
    bank_d      = bank_q;
    pend_bank_d = pend_bank_q;
    load_pend_d = load_pend_q;
    offset_d    = offset_q;
    word_cnt_d  = word_cnt_q;
    req_d       = req_q;
    addr_d      = addr_q;
    len_d       = len_q;
    done_d      = done_q;

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_WAIT_DATA: begin
        if (wr_load) begin
          state_d    = ST_WAIT_DATA;
          bank_d     = wr_bank;
          offset_d   = '0;
          word_cnt_d = '0;
          done_d     = 1'b0;
        end else if (state_q == ST_WAIT_DATA && fill_ok) begin
          state_d = ST_REQ;
          addr_d  = {bank_q, offset_q};
          len_d   = cur_len;
          req_d   = 1'b1;
        end
      end
      ST_REQ: begin
        if (wr_load) begin
          load_pend_d = 1'b1;
          pend_bank_d = wr_bank;
        end
        if (burst_ack) begin
          state_d = ST_BURST;
          req_d   = 1'b0;
        end
      end
      ST_BURST: begin
        if (burst_done) begin
          load_pend_d = 1'b0;
          offset_d    = off_next;
          word_cnt_d  = cnt_next;
          // A load landing on the done edge counts as pending too.
          if (wr_load || load_pend_q) begin
            state_d    = ST_WAIT_DATA;
            bank_d     = load_bank;
            offset_d   = '0;
            word_cnt_d = '0;
            done_d     = 1'b0;
          end else if (int'(cnt_next) == FRAME_WORDS) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_WAIT_DATA;
          end
        end else if (wr_load) begin
          load_pend_d = 1'b1;
          pend_bank_d = wr_bank;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bank_q      <= '0;
      pend_bank_q <= '0;
      load_pend_q <= 1'b0;
      offset_q    <= '0;
      word_cnt_q  <= '0;
      req_q       <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bank_q      <= bank_d;
      pend_bank_q <= pend_bank_d;
      load_pend_q <= load_pend_d;
      offset_q    <= offset_d;
      word_cnt_q  <= word_cnt_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      done_q      <= done_d;
    end
  end

  assign burst_req        = req_q;
  assign burst_addr       = addr_q;
  assign burst_len        = len_q;
  assign frame_write_done = done_q;

endmodule

// File: tb/tb_ddr_frame_wr_ctrl.sv
// Bench for ddr_frame_wr_ctrl: frame vector table, corner sequences
// and randomized traffic against a transaction-level model.
module tb_ddr_frame_wr_ctrl;

  localparam int AW = 24;
  localparam int LW = 9;
  localparam int UW = 10;
  localparam int FW = 600;
  localparam int BL = 256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    wr_bank = '0;
  logic          wr_load = 1'b0;
  logic [UW-1:0] fifo_usedw = '0;
  logic          burst_ack = 1'b0;
  logic          burst_done = 1'b0;
  logic          burst_req;
  logic [AW-1:0] burst_addr;
  logic [LW-1:0] burst_len;
  logic          frame_write_done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ddr_frame_wr_ctrl #(
    .ADDR_W(AW), .LEN_W(LW), .BURST_LEN(BL),
    .FRAME_WORDS(FW), .USEDW_W(UW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_bank(wr_bank), .wr_load(wr_load),
    .fifo_usedw(fifo_usedw),
    .burst_req(burst_req), .burst_addr(burst_addr),
    .burst_len(burst_len), .burst_ack(burst_ack),
    .burst_done(burst_done),
    .frame_write_done(frame_write_done)
  );

  typedef struct {
    logic [1:0]  bank;
    int          ack_dly;
    int          done_dly;
    logic [23:0] a0, a1, a2;
    int          l0, l1, l2;
  } frame_vec_t;

  frame_vec_t vecs[4];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    wr_load = 1'b0; burst_ack = 1'b0; burst_done = 1'b0;
    fifo_usedw = '1;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic load(input logic [1:0] b);
    wr_bank = b; wr_load = 1'b1;
    tick();
    wr_load = 1'b0;
  endtask

  task automatic wait_req(input string nm, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (burst_req) ok = 1'b1;
      else tick();
    end
    if (!ok) chk({nm, " req timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_burst(input string nm, input logic [23:0] ea,
                           input int el, input int ack_dly,
                           input int done_dly, input bit mid,
                           input logic [1:0] mb);
    bit ok;
    int bad;
    wait_req(nm, ok);
    if (!ok) return;
    chk({nm, " addr"}, burst_addr, ea);
    chk({nm, " len"}, burst_len, el);
    bad = 0;
    for (int i = 0; i < ack_dly; i++) begin
      tick();
      if (!burst_req || burst_addr !== ea || burst_len !== el[LW-1:0])
        bad++;
    end
    if (ack_dly > 0) chk({nm, " hold"}, bad, 0);
    burst_ack = 1'b1;
    tick();
    burst_ack = 1'b0;
    chk({nm, " req drop"}, burst_req, 0);
    if (mid) load(mb);
    for (int i = 0; i < done_dly; i++) tick();
    burst_done = 1'b1;
    tick();
    burst_done = 1'b0;
  endtask

  // Transaction-level reference state for the random phase
  bit m_wait, m_req, m_burst, m_pend, m_fwd;
  int m_bank, m_pbank, m_off, m_len;

  initial begin
    logic [23:0] ea[3];
    int el[3];
    int bad;
    bit pl, pa, pd;
    int pb, pu, exp_len;

    vecs[0] = '{2'b01, 0, 3, 24'h400000, 24'h400100, 24'h400200,
                256, 256, 88};
    vecs[1] = '{2'b10, 10, 1, 24'h800000, 24'h800100, 24'h800200,
                256, 256, 88};
    vecs[2] = '{2'b11, 2, 0, 24'hC00000, 24'hC00100, 24'hC00200,
                256, 256, 88};
    vecs[3] = '{2'b00, 1, 5, 24'h000000, 24'h000100, 24'h000200,
                256, 256, 88};

    do_reset();
    chk("reset req", burst_req, 0);
    chk("reset addr", burst_addr, 0);
    chk("reset len", burst_len, 0);
    chk("reset fwd", frame_write_done, 0);
    tick(); tick();
    chk("idle no req", burst_req, 0);

    // Frame vector table: full frames back to back
    for (int v = 0; v < 4; v++) begin
      ea[0] = vecs[v].a0; ea[1] = vecs[v].a1; ea[2] = vecs[v].a2;
      el[0] = vecs[v].l0; el[1] = vecs[v].l1; el[2] = vecs[v].l2;
      load(vecs[v].bank);
      chk($sformatf("v%0d fwd after load", v), frame_write_done, 0);
      chk($sformatf("v%0d wait cycle", v), burst_req, 0);
      tick();
      chk($sformatf("v%0d load->req", v), burst_req, 1);
      for (int b = 0; b < 3; b++) begin
        run_burst($sformatf("v%0d b%0d", v, b), ea[b], el[b],
                  vecs[v].ack_dly, vecs[v].done_dly, 1'b0, 2'b00);
        if (b < 2) begin
          chk($sformatf("v%0d b%0d fwd", v, b), frame_write_done, 0);
          chk($sformatf("v%0d b%0d gap", v, b), burst_req, 0);
          tick();
          chk($sformatf("v%0d b%0d done->req", v, b), burst_req, 1);
        end
      end
      chk($sformatf("v%0d fwd rise", v), frame_write_done, 1);
      tick(); tick();
      chk($sformatf("v%0d fwd held", v), frame_write_done, 1);
      chk($sformatf("v%0d no req in done", v), burst_req, 0);
    end

    // FIFO one word short of a full burst
    do_reset();
    fifo_usedw = 10'd255;
    load(2'b01);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (burst_req) bad++;
    end
    chk("usedw255 no req", bad, 0);
    fifo_usedw = 10'd256;
    tick();
    chk("usedw256 req", burst_req, 1);
    chk("usedw256 addr", burst_addr, 24'h400000);

    // Bank switch while the frame-closing burst is in flight
    do_reset();
    load(2'b01);
    run_burst("sw b0", 24'h400000, 256, 0, 2, 1'b0, 2'b00);
    run_burst("sw b1", 24'h400100, 256, 0, 2, 1'b0, 2'b00);
    run_burst("sw b2", 24'h400200, 88, 1, 2, 1'b1, 2'b10);
    chk("sw fwd suppressed", frame_write_done, 0);
    run_burst("sw new", 24'h800000, 256, 0, 1, 1'b0, 2'b00);
    chk("sw fwd still low", frame_write_done, 0);

    // Asynchronous reset during REQ
    do_reset();
    load(2'b11);
    tick();
    chk("rst pre req", burst_req, 1);
    rst_n = 1'b0;
    #1;
    chk("rst async req", burst_req, 0);
    chk("rst async addr", burst_addr, 0);
    chk("rst async len", burst_len, 0);
    chk("rst async fwd", frame_write_done, 0);
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (burst_req) bad++;
    end
    chk("rst no req after", bad, 0);
    load(2'b00);
    tick();
    chk("rst reload req", burst_req, 1);
    chk("rst reload addr", burst_addr, 24'h000000);

    // Randomized traffic against the reference model
    do_reset();
    m_wait = 0; m_req = 0; m_burst = 0; m_pend = 0; m_fwd = 0;
    m_bank = 0; m_pbank = 0; m_off = 0; m_len = 0;
    for (int c = 0; c < 4000; c++) begin
      pl = ($urandom_range(0, 99) <
            ((m_wait || m_req || m_burst) ? 2 : 15));
      pb = $urandom_range(0, 3);
      pu = $urandom_range(0, 1) ? $urandom_range(60, 300)
                                : $urandom_range(0, 1023);
      pa = m_req ? ($urandom_range(0, 2) == 0)
                 : ($urandom_range(0, 19) == 0);
      pd = m_burst ? ($urandom_range(0, 3) == 0)
                   : ($urandom_range(0, 19) == 0);
      wr_load = pl; wr_bank = 2'(pb);
      fifo_usedw = UW'(pu);
      burst_ack = pa; burst_done = pd;
      tick();

      exp_len = (FW - m_off < BL) ? FW - m_off : BL;
      if (!m_req && !m_burst && pl) begin
        m_bank = pb; m_off = 0; m_fwd = 0; m_wait = 1;
      end else if (m_wait && pu >= exp_len) begin
        m_wait = 0; m_req = 1; m_len = exp_len;
      end else if (m_req) begin
        if (pl) begin m_pend = 1; m_pbank = pb; end
        if (pa) begin m_req = 0; m_burst = 1; end
      end else if (m_burst) begin
        if (pd) begin
          m_burst = 0;
          if (m_pend || pl) begin
            m_bank = pl ? pb : m_pbank;
            m_off = 0; m_pend = 0; m_wait = 1;
          end else begin
            m_off += m_len;
            if (m_off == FW) m_fwd = 1;
            else m_wait = 1;
          end
        end else if (pl) begin
          m_pend = 1; m_pbank = pb;
        end
      end

      chk($sformatf("rnd c%0d req", c), burst_req, m_req);
      if (m_req) begin
        chk($sformatf("rnd c%0d addr", c), burst_addr,
            (m_bank << 22) | m_off);
        chk($sformatf("rnd c%0d len", c), burst_len, m_len);
      end
      chk($sformatf("rnd c%0d fwd", c), frame_write_done, m_fwd);
    end
    wr_load = 1'b0; burst_ack = 1'b0; burst_done = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
